// File: rtl/fifo_burst_pkg.sv
// Shared types for the burst drain engine that empties an upstream FIFO in bursts.
// Holds the controller state encoding.
package fifo_burst_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_burst_drain.sv
// Drains an upstream FIFO in bursts of up to BURST_LEN beats, or a partial burst after TIMEOUT idle cycles.
// Latency 1 cycle from pop to valid_o; backpressure: beat is held while !ready_i and popping stops until it leaves.
module fifo_burst_drain
    import fifo_burst_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter type         dtype      = logic [DATA_WIDTH-1:0],
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned TIMEOUT    = 16,
    localparam int unsigned UW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int unsigned LW = $clog2(BURST_LEN + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          full_i,
    input  logic          empty_i,
    input  logic [UW-1:0] usage_i,
    input  dtype          data_i,
    output logic          pop_o,
    input  logic          ready_i,
    output logic          valid_o,
    output dtype          data_o,
    output logic          last_o,
    output logic [LW-1:0] len_o
);

    localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e        state_q;
    logic [TW-1:0] tmo_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] pop_cnt_q;
    logic          vld_q;
    logic          last_q;
    dtype          dat_q;

    logic [FW-1:0] fill;
    logic          full_trig;
    logic          part_trig;
    logic          hs;
    logic          pop;

    // usage_i wraps to zero when the FIFO is full, so full_i overrides it
    assign fill      = full_i ? FW'(FIFO_DEPTH) : FW'(usage_i);
    assign full_trig = (fill >= FW'(BURST_LEN));
    assign part_trig = !empty_i && (tmo_q == TW'(TIMEOUT - 1));
    assign hs        = vld_q && ready_i;
    assign pop       = rst_ni && !flush_i && (state_q == BURST) && !empty_i
                    && (pop_cnt_q < len_q) && (!vld_q || ready_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            len_q     <= '0;
            pop_cnt_q <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            dat_q     <= '0;
        end else if (flush_i) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            len_q     <= '0;
            pop_cnt_q <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (full_trig) begin
                        state_q   <= BURST;
                        len_q     <= LW'(BURST_LEN);
                        pop_cnt_q <= '0;
                        tmo_q     <= '0;
                    end else if (part_trig) begin
                        state_q   <= BURST;
                        len_q     <= LW'(fill);
                        pop_cnt_q <= '0;
                        tmo_q     <= '0;
                    end else if (empty_i) begin
                        tmo_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                BURST: begin
                    if (pop) begin
                        dat_q     <= data_i;
                        vld_q     <= 1'b1;
                        last_q    <= (pop_cnt_q == len_q - LW'(1));
                        pop_cnt_q <= pop_cnt_q + LW'(1);
                    end else if (hs) begin
                        vld_q  <= 1'b0;
                        last_q <= 1'b0;
                    end
                    // the final beat can never overlap a pop, so the register empties here
                    if (hs && last_q) begin
                        state_q   <= IDLE;
                        tmo_q     <= '0;
                        pop_cnt_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pop_o   = pop;
    assign valid_o = vld_q;
    assign data_o  = dat_q;
    assign last_o  = last_q;
    assign len_o   = len_q;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Directed bench for fifo_burst_drain with a behavioural upstream FIFO (depth 8, burst 4, timeout 8).
module tb_fifo_burst_drain;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        ready_i;
    logic        full_i;
    logic        empty_i;
    logic [2:0]  usage_i;
    logic [31:0] data_i;
    logic        pop_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        last_o;
    logic [2:0]  len_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // upstream FIFO model
    logic        push_en;
    logic [31:0] push_dat;
    logic        fifo_clr;
    logic [31:0] mem [8];
    logic [2:0]  wp;
    logic [2:0]  rp;
    logic [3:0]  cnt;

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push_en) begin
                mem[wp] <= push_dat;
                wp      <= wp + 3'd1;
            end
            if (pop_o && cnt != 4'd0)
                rp <= rp + 3'd1;
            cnt <= cnt + 4'(push_en) - 4'(pop_o && cnt != 4'd0);
        end
    end

    assign empty_i = (cnt == 4'd0);
    assign full_i  = (cnt == 4'd8);
    assign usage_i = cnt[2:0];
    assign data_i  = mem[rp];

    fifo_burst_drain #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH(8),
        .BURST_LEN (4),
        .TIMEOUT   (8)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .flush_i(flush_i),
        .full_i (full_i),
        .empty_i(empty_i),
        .usage_i(usage_i),
        .data_i (data_i),
        .pop_o  (pop_o),
        .ready_i(ready_i),
        .valid_o(valid_o),
        .data_o (data_o),
        .last_o (last_o),
        .len_o  (len_o)
    );

    // pushes n words on consecutive cycles; returns at the negedge after the last push lands
    task automatic push_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push_en  = 1'b1;
            push_dat = base + 32'(i);
        end
        @(negedge clk);
        push_en = 1'b0;
    endtask

    task automatic test_reset;
        rst_ni   = 1'b0;
        fifo_clr = 1'b1;
        flush_i  = 1'b0;
        ready_i  = 1'b1;
        push_en  = 1'b0;
        push_dat = '0;
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_vec++; if (last_o !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", last_o); end
        n_vec++; if (len_o !== 3'd0) begin n_err++; $display("FAIL reset_len: got %0d want 0", len_o); end
        n_vec++; if (data_o !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", data_o); end
        n_vec++; if (pop_o !== 1'b0) begin n_err++; $display("FAIL reset_pop: got %b want 0", pop_o); end
        @(negedge clk);
        rst_ni   = 1'b1;
        fifo_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_burst;
        bit   [0:6]  ep = 7'b0111100;
        bit   [0:6]  ev = 7'b0011110;
        bit   [0:6]  el = 7'b0000010;
        logic [31:0] ed [7] = '{32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
        int          en [7] = '{-1, 4, 4, 4, 4, 4, -1};
        ready_i = 1'b1;
        push_words(4, 32'hA0);
        for (int c = 0; c < 7; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_vec++; if (pop_o !== ep[c]) begin n_err++; $display("FAIL full_pop c%0d: got %b want %b", c, pop_o, ep[c]); end
            n_vec++; if (valid_o !== ev[c]) begin n_err++; $display("FAIL full_valid c%0d: got %b want %b", c, valid_o, ev[c]); end
            n_vec++; if (last_o !== el[c]) begin n_err++; $display("FAIL full_last c%0d: got %b want %b", c, last_o, el[c]); end
            if (ev[c]) begin
                n_vec++; if (data_o !== ed[c]) begin n_err++; $display("FAIL full_data c%0d: got %h want %h", c, data_o, ed[c]); end
            end
            if (en[c] >= 0) begin
                n_vec++; if (len_o !== 3'(en[c])) begin n_err++; $display("FAIL full_len c%0d: got %0d want %0d", c, len_o, en[c]); end
            end
        end
    endtask

    task automatic test_partial;
        bit   [0:10] ep = 11'b00000001100;
        bit   [0:10] ev = 11'b00000000110;
        bit   [0:10] el = 11'b00000000010;
        logic [31:0] ed [11] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hB0, 32'hB1, 32'h0};
        int          en [11] = '{-1, -1, -1, -1, -1, -1, -1, 2, 2, 2, -1};
        ready_i = 1'b1;
        push_words(2, 32'hB0);
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_vec++; if (pop_o !== ep[c]) begin n_err++; $display("FAIL part_pop c%0d: got %b want %b", c, pop_o, ep[c]); end
            n_vec++; if (valid_o !== ev[c]) begin n_err++; $display("FAIL part_valid c%0d: got %b want %b", c, valid_o, ev[c]); end
            n_vec++; if (last_o !== el[c]) begin n_err++; $display("FAIL part_last c%0d: got %b want %b", c, last_o, el[c]); end
            if (ev[c]) begin
                n_vec++; if (data_o !== ed[c]) begin n_err++; $display("FAIL part_data c%0d: got %h want %h", c, data_o, ed[c]); end
            end
            if (en[c] >= 0) begin
                n_vec++; if (len_o !== 3'(en[c])) begin n_err++; $display("FAIL part_len c%0d: got %0d want %0d", c, len_o, en[c]); end
            end
        end
    endtask

    task automatic test_ready_toggle;
        int          nb = 0;
        int          np = 0;
        logic        stall = 1'b0;
        logic [31:0] pd = '0;
        logic        pl = 1'b0;
        ready_i = 1'b1;
        push_words(4, 32'hC0);
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            ready_i = (cyc % 2 == 0);
            #1;
            if (pop_o) np++;
            if (valid_o) begin
                if (stall) begin
                    n_vec++; if (data_o !== pd || last_o !== pl) begin n_err++; $display("FAIL toggle_stable cyc%0d: got %h/%b want %h/%b", cyc, data_o, last_o, pd, pl); end
                end
                if (ready_i) begin
                    if (nb < 4) begin
                        n_vec++; if (data_o !== 32'hC0 + 32'(nb)) begin n_err++; $display("FAIL toggle_data beat%0d: got %h want %h", nb, data_o, 32'hC0 + 32'(nb)); end
                        n_vec++; if (last_o !== (nb == 3)) begin n_err++; $display("FAIL toggle_last beat%0d: got %b want %b", nb, last_o, nb == 3); end
                        n_vec++; if (len_o !== 3'd4) begin n_err++; $display("FAIL toggle_len beat%0d: got %0d want 4", nb, len_o); end
                    end
                    nb++;
                end
            end
            stall = valid_o && !ready_i;
            pd    = data_o;
            pl    = last_o;
        end
        ready_i = 1'b1;
        n_vec++; if (nb != 4) begin n_err++; $display("FAIL toggle_beats: got %0d want 4", nb); end
        n_vec++; if (np != 4) begin n_err++; $display("FAIL toggle_pops: got %0d want 4", np); end
    endtask

    task automatic test_full_flag;
        int nb = 0;
        ready_i = 1'b1;
        flush_i = 1'b1;
        push_words(8, 32'hD0);
        flush_i = 1'b0;
        #1;
        n_vec++; if (pop_o !== 1'b0) begin n_err++; $display("FAIL fullflag_idle_pop: got %b want 0", pop_o); end
        @(negedge clk);
        #1;
        n_vec++; if (pop_o !== 1'b1) begin n_err++; $display("FAIL fullflag_pop: got %b want 1", pop_o); end
        n_vec++; if (len_o !== 3'd4) begin n_err++; $display("FAIL fullflag_len: got %0d want 4", len_o); end
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                #1;
            end
            if (valid_o) begin
                if (nb < 8) begin
                    n_vec++; if (data_o !== 32'hD0 + 32'(nb)) begin n_err++; $display("FAIL fullflag_data beat%0d: got %h want %h", nb, data_o, 32'hD0 + 32'(nb)); end
                    n_vec++; if (last_o !== (nb == 3 || nb == 7)) begin n_err++; $display("FAIL fullflag_last beat%0d: got %b want %b", nb, last_o, nb == 3 || nb == 7); end
                    n_vec++; if (len_o !== 3'd4) begin n_err++; $display("FAIL fullflag_beatlen beat%0d: got %0d want 4", nb, len_o); end
                end
                nb++;
            end
        end
        n_vec++; if (nb != 8) begin n_err++; $display("FAIL fullflag_beats: got %0d want 8", nb); end
    endtask

    task automatic test_flush;
        bit   [0:15] fl = 16'b0000100000000000;
        bit   [0:15] ep = 16'b0111000000000100;
        bit   [0:15] ev = 16'b0011100000000010;
        bit   [0:15] el = 16'b0000000000000010;
        logic [31:0] ed [16] = '{32'h0, 32'h0, 32'hE0, 32'hE1, 32'hE2, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hE3, 32'h0};
        int          en [16] = '{-1, 4, 4, 4, 4, -1, -1, -1, -1, -1, -1, -1, -1, 1, 1, -1};
        ready_i = 1'b1;
        push_words(4, 32'hE0);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            flush_i = fl[c];
            #1;
            n_vec++; if (pop_o !== ep[c]) begin n_err++; $display("FAIL flush_pop c%0d: got %b want %b", c, pop_o, ep[c]); end
            n_vec++; if (valid_o !== ev[c]) begin n_err++; $display("FAIL flush_valid c%0d: got %b want %b", c, valid_o, ev[c]); end
            n_vec++; if (last_o !== el[c]) begin n_err++; $display("FAIL flush_last c%0d: got %b want %b", c, last_o, el[c]); end
            if (ev[c]) begin
                n_vec++; if (data_o !== ed[c]) begin n_err++; $display("FAIL flush_data c%0d: got %h want %h", c, data_o, ed[c]); end
            end
            if (en[c] >= 0) begin
                n_vec++; if (len_o !== 3'(en[c])) begin n_err++; $display("FAIL flush_len c%0d: got %0d want %0d", c, len_o, en[c]); end
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit   [0:15] rs = 16'b0001000000000000;
        bit   [0:15] ep = 16'b0110000000001100;
        bit   [0:15] ev = 16'b0011000000000110;
        bit   [0:15] el = 16'b0000000000000010;
        bit   [0:15] dc = 16'b0011100000000110;
        logic [31:0] ed [16] = '{32'h0, 32'h0, 32'hF0, 32'hF1, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hF2, 32'hF3, 32'h0};
        int          en [16] = '{-1, 4, 4, 4, 0, -1, -1, -1, -1, -1, -1, -1, 2, 2, 2, -1};
        ready_i = 1'b1;
        push_words(4, 32'hF0);
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            rst_ni = !rs[c];
            #1;
            n_vec++; if (pop_o !== ep[c]) begin n_err++; $display("FAIL rstmid_pop c%0d: got %b want %b", c, pop_o, ep[c]); end
            n_vec++; if (valid_o !== ev[c]) begin n_err++; $display("FAIL rstmid_valid c%0d: got %b want %b", c, valid_o, ev[c]); end
            n_vec++; if (last_o !== el[c]) begin n_err++; $display("FAIL rstmid_last c%0d: got %b want %b", c, last_o, el[c]); end
            if (dc[c]) begin
                n_vec++; if (data_o !== ed[c]) begin n_err++; $display("FAIL rstmid_data c%0d: got %h want %h", c, data_o, ed[c]); end
            end
            if (en[c] >= 0) begin
                n_vec++; if (len_o !== 3'(en[c])) begin n_err++; $display("FAIL rstmid_len c%0d: got %0d want %0d", c, len_o, en[c]); end
            end
        end
        rst_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_partial();
        test_ready_toggle();
        test_full_flag();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
